// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall, relative branch, absolute jump and
// call/return through a circular return-address stack with sticky error flags.
module pc_sequencer #(
    parameter int unsigned XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h3000,
    parameter int unsigned INSTR_BYTES  = 4,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           branch_en,
    input  logic [XLEN-1:0]                branch_offset,
    input  logic                           jump_en,
    input  logic [XLEN-1:0]                jump_target,
    input  logic                           call,
    input  logic                           ret,
    output logic [XLEN-1:0]                pc_out,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int unsigned PtrW  = $clog2(RAS_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned Shift = $clog2(INSTR_BYTES);

    localparam logic [XLEN-1:0] Step      = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] AlignMask = ~(Step - XLEN'(1));
    localparam logic [CntW-1:0] CntFull   = CntW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] top_q, top_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push_en;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    assign pc_seq = pc_q + Step;

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            // ret outranks jump, so a push and a pop never share a cycle
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_q[top_q];
                    cnt_d = cnt_q - CntW'(1);
                    top_d = top_q - PtrW'(1);
                end else begin
                    pc_d  = pc_seq;
                    unf_d = 1'b1;
                end
            end else if (jump_en) begin
                pc_d = jump_target & AlignMask;
                if (call) begin
                    push_en = 1'b1;
                    top_d   = top_q + PtrW'(1);
                    // A full stack overwrites its oldest slot, which is top+1
                    if (cnt_q == CntFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end else if (branch_en) begin
                pc_d = pc_q + (branch_offset << Shift);
            end else begin
                pc_d = pc_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR - Step;
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            ras_q[top_d] <= pc_seq;
        end
    end

    assign pc_out        = pc_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle presents a new registered output; pop and compare
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (pc_out !== e.pc) begin
                n_bad++;
                $display("FAIL pc[%0d]: got %h want %h", e.idx, pc_out, e.pc);
            end
            n_cmp++;
            if (ras_count !== e.cnt) begin
                n_bad++;
                $display("FAIL ras_count[%0d]: got %0d want %0d", e.idx, ras_count, e.cnt);
            end
            n_cmp++;
            if (ras_overflow !== e.ovf) begin
                n_bad++;
                $display("FAIL ras_overflow[%0d]: got %b want %b", e.idx, ras_overflow, e.ovf);
            end
            n_cmp++;
            if (ras_underflow !== e.unf) begin
                n_bad++;
                $display("FAIL ras_underflow[%0d]: got %b want %b", e.idx, ras_underflow,
                         e.unf);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after that edge
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] off,
                       input logic j, input logic [31:0] tgt, input logic c, input logic rt,
                       input logic [31:0] epc, input logic [2:0] ecnt, input logic eo,
                       input logic eu);
        exp_t e;
        rst = r; stall = s; branch_en = b; branch_offset = off;
        jump_en = j; jump_target = tgt; call = c; ret = rt;
        @(posedge clk);
        #1;
        e.idx = n_vec; e.pc = epc; e.cnt = ecnt; e.ovf = eo; e.unf = eu;
        exp_q.push_back(e);
        n_vec++;
    endtask

    initial begin
        // Reset and free-run
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 32'h2FFC, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3000, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3004, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3008, 0, 0, 0);
        // Branches from 0x3008
        cyc(0, 0, 1, -32'sd2, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3004, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3008, 0, 0, 0);
        cyc(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h3108, 0, 0, 0);
        // Unaligned jump gets its low bits cleared, then wrap-around
        cyc(0, 0, 0, 0,   1, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
        cyc(0, 0, 1, -32'sd1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 1, 32'd2, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0);
        // Call/return nesting
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 32'h2FFC, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3000, 0, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h4000, 1, 0, 32'h4000, 1, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h4004, 1, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h5002, 1, 0, 32'h5000, 2, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h4008, 1, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h3004, 0, 0, 0);
        // call without jump_en is a plain step
        cyc(0, 0, 0, 0,   0, 0, 1, 0, 32'h3008, 0, 0, 0);
        // Stall freezes everything; then ret beats jump+call
        cyc(0, 0, 0, 0,   1, 32'h6000, 1, 0, 32'h6000, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 32'd5, 1, 32'h7000, 0, 1, 32'h6000, 1, 0, 0);
        end
        cyc(0, 0, 0, 0,   1, 32'h7000, 1, 1, 32'h300C, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3010, 0, 0, 0);
        // RAS limits
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 32'h2FFC, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3000, 0, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h100, 1, 0, 32'h100, 1, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h200, 1, 0, 32'h200, 2, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h300, 1, 0, 32'h300, 3, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h400, 1, 0, 32'h400, 4, 0, 0);
        cyc(0, 0, 0, 0,   1, 32'h500, 1, 0, 32'h500, 4, 1, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h404, 3, 1, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h304, 2, 1, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h204, 1, 1, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h104, 0, 1, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 32'h108, 0, 1, 1);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h10C, 0, 1, 1);
        cyc(0, 1, 0, 0,   0, 0, 0, 1, 32'h10C, 0, 1, 1);
        // Reset overrides other inputs and clears the sticky flags
        cyc(1, 0, 1, 32'd3, 1, 32'h8000, 1, 1, 32'h2FFC, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3000, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 32'h3004, 0, 0, 0);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It replaces the fixed 32-bit, branch-or-increment counter. Width, reset vector and instruction size are configurable. Adds stall, absolute jumps, call/return through an internal return-address stack (RAS), and sticky RAS error flags. Drives the instruction-memory address every cycle.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h3000: address of the first fetched instruction.
- INSTR_BYTES, 4: bytes per instruction; power of two, ≥1.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS; all other requests ignored.
- branch_en  in  1  take a PC-relative branch (ALU zero result).
- branch_offset  in  XLEN  signed offset in instructions.
- jump_en  in  1  absolute jump to jump_target.
- jump_target  in  XLEN  byte address.
- call  in  1  qualifies jump_en: push the return address.
- ret  in  1  pop the RAS top into the PC.
- pc_out  out  XLEN  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky: a push was made into a full RAS.
- ras_underflow  out  1  sticky: a ret was made on an empty RAS.

## Operation
- Reset, taking effect on the clock edge with rst=1:
  - pc_out = RESET_VECTOR − INSTR_BYTES, so the first non-stalled cycle presents RESET_VECTOR.
  - ras_count = 0, ras_overflow = 0, ras_underflow = 0.
  - RAS contents are don't-care.
- rst has priority over every other input.
- Per-edge next-PC selection, highest priority first:
  1. stall: pc_out and RAS unchanged.
  2. ret:
     - RAS non-empty: pc_out ← top entry, ras_count−1.
     - RAS empty: pc_out ← pc_out + INSTR_BYTES, ras_underflow ← 1.
  3. jump_en: pc_out ← jump_target with the low log2(INSTR_BYTES) bits forced to 0. If call=1, also push pc_out + INSTR_BYTES.
  4. branch_en: pc_out ← pc_out + branch_offset × INSTR_BYTES.
  5. Otherwise: pc_out ← pc_out + INSTR_BYTES.
- call without jump_en has no effect. ret with jump_en executes only the ret; the jump and any push are dropped.
- Arithmetic:
  - All sums are taken modulo 2^XLEN and wrap silently.
  - branch_offset is two's complement; the product is truncated to XLEN bits.
- RAS:
  - Circular buffer with a top pointer; the push writes at the top pointer+1.
  - Push when ras_count = RAS_DEPTH: the oldest entry is overwritten, ras_count stays RAS_DEPTH, ras_overflow ← 1.
  - Pop returns the most recent entry (LIFO).
  - After an overflow, RAS_DEPTH pops return the newest RAS_DEPTH addresses. The next pop underflows.
- ras_overflow and ras_underflow clear only on rst.

## Timing
- Single-cycle latency: inputs sampled at edge N determine pc_out after edge N.
- pc_out, ras_count and the flags are registers; no combinational input-to-output path.
- Stall is held indefinitely with no loss of state. Requests presented during a stall are discarded, not queued.
- A RAS push and pop never occur in the same cycle, because ret wins.
- Reset asserted mid-operation:
  - The next edge restores all reset values regardless of other inputs.
  - The first edge after rst deasserts behaves like any other cycle. With no requests, pc_out becomes RESET_VECTOR.

## Test plan
- Reset then free-run, with defaults: pc_out = 0x2FFC after reset, then 0x3000, 0x3004, 0x3008 on successive edges; ras_count = 0.
- Branch, starting from pc_out = 0x3008:
  - branch_offset = −2 → 0x3000.
  - branch_offset = 0x40 → 0x3108.
- Branch wrap, starting from pc_out = 0xFFFFFFFC: a sequential step → 0x00000000.
- Call/return nesting:
  - At pc 0x3000, jump_en + call to 0x4000, then at 0x4004 call to 0x5002 → pc 0x5000, ras_count = 2.
  - First ret → 0x4008.
  - Second ret → 0x3004, ras_count = 0.
- Stall and priority:
  - stall with ret, jump_en and branch_en all asserted for 3 cycles → pc_out and ras_count frozen.
  - Release stall, then drive ret + jump_en on the same cycle → the pop target is taken, with no push.
- RAS limits, with RAS_DEPTH = 4:
  - 5 calls → ras_overflow = 1, ras_count = 4.
  - 4 rets return the newest 4 addresses in reverse order.
  - A 5th ret → pc +4, ras_underflow = 1.
  - rst → both flags 0.
